conv1d_stream: RTL



---
 rtl/conv1d_stream_pkg.sv | 18 +
 rtl/conv1d_stream_if.sv | 35 +++
 rtl/conv1d_stream_mac.sv | 34 +++
 rtl/conv1d_stream.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/conv1d_stream_pkg.sv
// Shared types and width helpers for the streaming 1-D convolution engine.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } conv_state_t;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps) + 1;
  endfunction

  function automatic int addr_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/conv1d_stream_if.sv
// Sample/result streams, coefficient load port and status for conv1d_stream.
interface conv1d_stream_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 3
) ();
  import conv_pkg::*;

  localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
  localparam int AW    = addr_width(TAPS);

  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [ACC_W-1:0]  m_data;
  logic              m_last;
  logic              busy;

  modport master (
    output coef_we, coef_addr, coef_data, s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, busy
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, busy
  );

endinterface

// File: rtl/conv1d_stream_mac.sv
// Combinational TAPS-wide multiply-accumulate; operands are extended to the
// full accumulator width so the modular sum equals the exact result.
module conv1d_mac #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 3,
  parameter int ACC_W  = 19,
  parameter bit SIGNED = 1'b1
) (
  input  logic [DATA_W-1:0] i_hist [TAPS],
  input  logic [COEF_W-1:0] i_coef [TAPS],
  output logic [ACC_W-1:0]  o_acc
);

  logic [ACC_W-1:0] w_x;
  logic [ACC_W-1:0] w_h;

  always_comb begin
    o_acc = {ACC_W{1'b0}};
    w_x   = {ACC_W{1'b0}};
    w_h   = {ACC_W{1'b0}};
    for (int k = 0; k < TAPS; k++) begin
      if (SIGNED) begin
        w_x = {{(ACC_W-DATA_W){i_hist[k][DATA_W-1]}}, i_hist[k]};
        w_h = {{(ACC_W-COEF_W){i_coef[k][COEF_W-1]}}, i_coef[k]};
      end else begin
        w_x = {{(ACC_W-DATA_W){1'b0}}, i_hist[k]};
        w_h = {{(ACC_W-COEF_W){1'b0}}, i_coef[k]};
      end
      o_acc = o_acc + w_x * w_h;
    end
  end

endmodule

// File: rtl/conv1d_stream.sv
// Streaming full 1-D convolution: N samples in, N+TAPS-1 registered results out,
// with a zero-shifting FLUSH phase and an IDLE-only coefficient bank.
module conv1d_stream
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 3,
  parameter bit SIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  conv1d_stream_if.slave  bus
);

  localparam int ACC_W   = acc_width(DATA_W, COEF_W, TAPS);
  localparam int AW      = addr_width(TAPS);
  localparam int FLUSH_N = (TAPS > 1) ? TAPS - 1 : 1;
  localparam logic [AW-1:0] CNT_LAST = AW'(FLUSH_N - 1);

  conv_state_t       r_state;
  conv_state_t       w_state_nxt;
  logic [DATA_W-1:0] r_hist [TAPS];
  logic [DATA_W-1:0] w_hist [TAPS];
  logic [COEF_W-1:0] r_coef [TAPS];
  logic [AW-1:0]     r_cnt;
  logic              r_started;
  logic              r_m_valid;
  logic              r_m_last;
  logic [ACC_W-1:0]  r_m_data;
  logic [ACC_W-1:0]  w_dot;
  logic              w_out_free;
  logic              w_s_ready;
  logic              w_accept;
  logic              w_flush_step;
  logic              w_flush_done;
  logic              w_shift;
  logic              w_last_beat;
  logic              w_coef_wr;

  assign w_out_free   = !r_m_valid || bus.m_ready;
  assign w_s_ready    = r_started && (r_state != FLUSH) && w_out_free;
  assign w_accept     = bus.s_valid && w_s_ready;
  assign w_flush_step = (r_state == FLUSH) && w_out_free;
  assign w_flush_done = w_flush_step && (r_cnt == CNT_LAST);
  assign w_shift      = w_accept || w_flush_step;
  assign w_last_beat  = w_flush_done || ((TAPS == 1) && w_accept && bus.s_last);
  assign w_coef_wr    = bus.coef_we && (r_state == IDLE) && !w_accept &&
                        (32'(bus.coef_addr) < 32'(TAPS));

  // History as it will look after this cycle's shift (sample or flush zero).
  always_comb begin
    w_hist[0] = w_accept ? bus.s_data : {DATA_W{1'b0}};
    for (int k = 1; k < TAPS; k++) begin
      w_hist[k] = r_hist[k-1];
    end
  end

  conv1d_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .TAPS   (TAPS),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .i_hist (w_hist),
    .i_coef (r_coef),
    .o_acc  (w_dot)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, RUN: begin
        if (w_accept && bus.s_last) begin
          w_state_nxt = (TAPS > 1) ? FLUSH : IDLE;
        end else if (w_accept) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = r_state;
        end
      end
      FLUSH: begin
        if (w_flush_done) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = FLUSH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= {AW{1'b0}};
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
      if ((r_state != FLUSH) || w_flush_done) begin
        r_cnt <= {AW{1'b0}};
      end else if (w_flush_step) begin
        r_cnt <= r_cnt + AW'(1);
      end
    end
  end

  // The frame's final beat leaves the history cleared for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) r_hist[k] <= {DATA_W{1'b0}};
    end else if (w_last_beat) begin
      for (int k = 0; k < TAPS; k++) r_hist[k] <= {DATA_W{1'b0}};
    end else if (w_shift) begin
      r_hist <= w_hist;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) r_coef[k] <= {COEF_W{1'b0}};
    end else if (w_coef_wr) begin
      r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= {ACC_W{1'b0}};
      r_m_last  <= 1'b0;
    end else if (w_shift) begin
      r_m_valid <= 1'b1;
      r_m_data  <= w_dot;
      r_m_last  <= w_last_beat;
    end else if (bus.m_ready) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;
  assign bus.m_last  = r_m_last;
  assign bus.busy    = (r_state != IDLE);

endmodule
